// File: rtl/seg_scan_controller.sv
// ----------------------------------------------------------------------------
// seg_scan_controller
//
// Time-multiplexed driver for an 8-digit, common-anode 7-segment display that
// shows the state of a two-dice game.
//
//   digit 0 : die 1 value (dash when out of 1..6)
//   digit 1 : die 2 value (dash when out of 1..6)
//   digit 3 : ones of die1+die2 (blank if either die is invalid)
//   digit 4 : tens of die1+die2 (blank if sum < 10 or either die invalid)
//   digit 7 : status  E (win&lose), blinking P (win), blinking L (lose),
//             r (roll), else blank
//   digits 2, 5, 6 : always blank
//
// Game inputs are sampled once per full 8-digit frame so that a frame never
// mixes old and new values.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit slot (>= 4)
//   BLINK_FRAMES : full frames per blink half-period (>= 1)
//
// Ports
//   CLK        in   system clock, rising-edge
//   reset      in   synchronous, active-high reset
//   Win        in   game-won level
//   Lose       in   game-lost level
//   Roll       in   awaiting-roll level
//   Dice1[2:0] in   die 1 value
//   Dice2[2:0] in   die 2 value
//   Anode[7:0] out  digit enables, active-low (bit n = digit n), registered
//   Cathode[6:0] out segments {g,f,e,d,c,b,a}, active-low, registered
// ----------------------------------------------------------------------------
module seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Win,
    input  logic       Lose,
    input  logic       Roll,
    input  logic [2:0] Dice1,
    input  logic [2:0] Dice2,
    output logic [7:0] Anode,
    output logic [6:0] Cathode
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] GLY_BLANK = 7'h7F;
    localparam logic [6:0] GLY_DASH  = 7'h3F;
    localparam logic [6:0] GLY_R     = 7'h2F;
    localparam logic [6:0] GLY_P     = 7'h0C;
    localparam logic [6:0] GLY_L     = 7'h47;
    localparam logic [6:0] GLY_E     = 7'h06;

    // Decimal digit to segment pattern; anything above 9 is blank.
    function automatic logic [6:0] digit_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = GLY_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic die_valid(input logic [2:0] v);
        return (v != 3'd0) && (v != 3'd7);
    endfunction

    function automatic logic [6:0] die_glyph(input logic [2:0] v);
        return die_valid(v) ? digit_glyph({1'b0, v}) : GLY_DASH;
    endfunction

    // Status digit: win&lose is a fault indication and never blinks.
    function automatic logic [6:0] status_glyph(input logic win, input logic lose,
                                                input logic roll, input logic bp);
        logic [6:0] g;
        if (win && lose) begin
            g = GLY_E;
        end else if (win) begin
            g = bp ? GLY_P : GLY_BLANK;
        end else if (lose) begin
            g = bp ? GLY_L : GLY_BLANK;
        end else if (roll) begin
            g = GLY_R;
        end else begin
            g = GLY_BLANK;
        end
        return g;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dig_q, dig_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             bp_q, bp_d;
    logic             win_q, win_d, lose_q, lose_d, roll_q, roll_d;
    logic [2:0]       d1_q, d1_d, d2_q, d2_d;
    logic [7:0]       anode_q, anode_d;
    logic [6:0]       cathode_q, cathode_d;

    logic             tick_s;
    logic             frame_end_s;
    logic [3:0]       sum_s;
    logic [3:0]       ones_s;
    logic             sum_ge10_s;
    logic             dice_ok_s;

    // Next-state logic for prescaler, scan position, blink timing, snapshot and outputs.
    always_comb begin
        cnt_d     = cnt_q;
        dig_d     = dig_q;
        frm_d     = frm_q;
        bp_d      = bp_q;
        win_d     = win_q;
        lose_d    = lose_q;
        roll_d    = roll_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        anode_d   = 8'hFF;
        cathode_d = GLY_BLANK;

        tick_s      = (cnt_q == CNT_LAST);
        frame_end_s = tick_s && (dig_q == 3'd7);

        // Sum is formed only from the snapshot so the whole frame is coherent.
        sum_s      = {1'b0, d1_q} + {1'b0, d2_q};
        sum_ge10_s = (sum_s >= 4'd10);
        ones_s     = sum_ge10_s ? (sum_s - 4'd10) : sum_s;
        dice_ok_s  = die_valid(d1_q) && die_valid(d2_q);

        if (tick_s) begin
            cnt_d = '0;
            dig_d = dig_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (frame_end_s) begin
            win_d  = Win;
            lose_d = Lose;
            roll_d = Roll;
            d1_d   = Dice1;
            d2_d   = Dice2;
            if (frm_q == FRM_LAST) begin
                frm_d = '0;
                bp_d  = ~bp_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end else begin
            frm_d = frm_q;
        end

        // First two cycles of every slot keep all digits dark to avoid ghosting.
        if (cnt_q < CNT_W'(2)) begin
            anode_d = 8'hFF;
        end else begin
            anode_d = ~(8'd1 << dig_q);
        end

        case (dig_q)
            3'd0:    cathode_d = die_glyph(d1_q);
            3'd1:    cathode_d = die_glyph(d2_q);
            3'd3:    cathode_d = dice_ok_s ? digit_glyph(ones_s) : GLY_BLANK;
            3'd4:    cathode_d = (dice_ok_s && sum_ge10_s) ? digit_glyph(4'd1) : GLY_BLANK;
            3'd7:    cathode_d = status_glyph(win_q, lose_q, roll_q, bp_q);
            default: cathode_d = GLY_BLANK;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q     <= '0;
            dig_q     <= 3'd0;
            frm_q     <= '0;
            bp_q      <= 1'b1;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            roll_q    <= 1'b0;
            d1_q      <= 3'd0;
            d2_q      <= 3'd0;
            anode_q   <= 8'hFF;
            cathode_q <= GLY_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            frm_q     <= frm_d;
            bp_q      <= bp_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            roll_q    <= roll_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign Anode   = anode_q;
    assign Cathode = cathode_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for seg_scan_controller with REFRESH_DIV=4 and
// BLINK_FRAMES=2. After reset release, edge E0 is the first edge with reset
// low; the output seen after edge Ek reflects the scan state before Ek, so
// digit d of frame f is displayed after edges 32f+4d .. 32f+4d+3 and its
// Anode bit is low after the last two of those. Snapshots are taken at edge
// 32f-1, and blink phase starts at 1 and flips at every second capture.
// ----------------------------------------------------------------------------
module tb_seg_scan_controller;

    logic       CLK;
    logic       reset;
    logic       Win;
    logic       Lose;
    logic       Roll;
    logic [2:0] Dice1;
    logic [2:0] Dice2;
    logic [7:0] Anode;
    logic [6:0] Cathode;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] an_exp [8];

    seg_scan_controller #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .Win     (Win),
        .Lose    (Lose),
        .Roll    (Roll),
        .Dice1   (Dice1),
        .Dice2   (Dice2),
        .Anode   (Anode),
        .Cathode (Cathode)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_an(input string tag, input logic [7:0] exp);
        checks++;
        assert (Anode === exp) else begin
            errors++;
            $error("FAIL %s (cyc %0d): Anode got %h expected %h", tag, cyc, Anode, exp);
        end
    endtask

    task automatic chk_cat(input string tag, input logic [6:0] exp);
        checks++;
        assert (Cathode === exp) else begin
            errors++;
            $error("FAIL %s (cyc %0d): Cathode got %h expected %h", tag, cyc, Cathode, exp);
        end
    endtask

    // One clock edge, sample 1 time unit later, and check at most one digit is on.
    task automatic clk1();
        @(posedge CLK);
        #1;
        cyc++;
        checks++;
        assert ($countones(~Anode) <= 1) else begin
            errors++;
            $error("FAIL onehot (cyc %0d): Anode got %h expected at most one low bit", cyc, Anode);
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) clk1();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1();
        clk1();
        chk_an("reset_anode", 8'hFF);
        chk_cat("reset_cathode", 7'h7F);
        reset = 1'b0;
        cyc = -1;
    endtask

    initial begin
        reset = 1'b1;
        Win = 1'b0; Lose = 1'b0; Roll = 1'b0;
        Dice1 = 3'd0; Dice2 = 3'd0;
        an_exp = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD, 8'hFD};

        // Idle scan: anode pattern, dashes for dice, blank status.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_to(i);
            chk_an("idle_anode_seq", an_exp[i]);
            if (i == 2) chk_cat("idle_d0_dash", 7'h3F);
            if (i == 6) chk_cat("idle_d1_dash", 7'h3F);
        end
        run_to(14);  chk_cat("idle_d3_blank", 7'h7F);
        run_to(26);  chk_an("idle_d6_anode", 8'hBF);
        run_to(30);  chk_an("idle_d7_anode", 8'h7F);
                     chk_cat("idle_d7_blank", 7'h7F);
        run_to(34);  chk_cat("idle_f1_d0_dash", 7'h3F);
        run_to(62);  chk_cat("idle_f1_d7_blank", 7'h7F);

        // Win with 3+4: values appear after first capture, P blinks.
        Dice1 = 3'd3; Dice2 = 3'd4; Win = 1'b1;
        do_reset();
        run_to(2);   chk_cat("win_f0_d0_dash", 7'h3F);
        run_to(30);  chk_cat("win_f0_d7_blank", 7'h7F);
        run_to(34);  chk_cat("win_d0_3", 7'h30);
        run_to(38);  chk_cat("win_d1_4", 7'h19);
        run_to(42);  chk_cat("win_d2_blank", 7'h7F);
        run_to(46);  chk_cat("win_d3_7", 7'h78);
        run_to(50);  chk_cat("win_d4_blank", 7'h7F);
        run_to(62);  chk_cat("win_f1_d7_P", 7'h0C);
        run_to(94);  chk_cat("win_f2_d7_off", 7'h7F);
        // Reset for one cycle at dig=5, cnt=2 (pre-edge at E118).
        run_to(117);
        reset = 1'b1;
        clk1();
        chk_an("midreset_anode", 8'hFF);
        chk_cat("midreset_cathode", 7'h7F);
        reset = 1'b0;
        cyc = -1;
        run_to(0);   chk_an("resume_e0_anode", 8'hFF);
                     chk_cat("resume_e0_dash", 7'h3F);
        run_to(2);   chk_an("resume_e2_anode", 8'hFE);
        run_to(30);  chk_cat("resume_f0_d7_blank", 7'h7F);
        run_to(62);  chk_cat("resume_f1_d7_P", 7'h0C);

        // Lose with 6+5: sum 11, L blinks; then win&lose gives steady E.
        Dice1 = 3'd6; Dice2 = 3'd5; Win = 1'b0; Lose = 1'b1;
        do_reset();
        run_to(46);  chk_cat("lose_d3_1", 7'h79);
        run_to(50);  chk_cat("lose_d4_1", 7'h79);
        run_to(62);  chk_cat("lose_f1_d7_L", 7'h47);
        run_to(94);  chk_cat("lose_f2_d7_off", 7'h7F);
        run_to(100);
        Win = 1'b1;
        run_to(126); chk_cat("lose_f3_d7_not_yet", 7'h7F);
        run_to(158); chk_cat("winlose_f4_E", 7'h06);
        run_to(222); chk_cat("winlose_f6_E", 7'h06);

        // Mid-frame input changes are held off until the next capture.
        Win = 1'b0; Lose = 1'b0; Dice1 = 3'd2; Dice2 = 3'd1;
        do_reset();
        run_to(34);  chk_cat("hold_f1_d0_2", 7'h24);
        run_to(49);
        Dice1 = 3'd5;
        run_to(66);  chk_cat("hold_f2_d0_5", 7'h12);
        run_to(65);
        Dice1 = 3'd4;
        run_to(67);  chk_cat("hold_f2_d0_still5", 7'h12);
        run_to(78);  chk_cat("hold_f2_d3_6", 7'h02);
        run_to(98);  chk_cat("hold_f3_d0_4", 7'h19);

        // Invalid dice with Roll.
        Dice1 = 3'd7; Dice2 = 3'd0; Roll = 1'b1;
        do_reset();
        run_to(34);  chk_cat("roll_d0_dash", 7'h3F);
        run_to(38);  chk_cat("roll_d1_dash", 7'h3F);
        run_to(46);  chk_cat("roll_d3_blank", 7'h7F);
        run_to(50);  chk_cat("roll_d4_blank", 7'h7F);
        run_to(62);  chk_cat("roll_f1_d7_r", 7'h2F);
        run_to(94);  chk_cat("roll_f2_d7_r", 7'h2F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot; legal range >= 4.
REQ-002 Parameter BLINK_FRAMES, default 64: full 8-digit scan frames per blink half-period; legal range >= 1.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Win  input  1  game-won level from the dice game.
REQ-006 Lose  input  1  game-lost level from the dice game.
REQ-007 Roll  input  1  awaiting-roll level from the dice game.
REQ-008 Dice1  input  3  die 1 value; valid range 1..6.
REQ-009 Dice2  input  3  die 2 value; valid range 1..6.
REQ-010 Anode  output  8  digit enables, active-low; bit n enables digit n.
REQ-011 Cathode  output  7  segments, active-low; bit order {g,f,e,d,c,b,a}.

Function
REQ-012 The prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the tick.
REQ-013 On each tick, digit index dig (3 bits) SHALL increment; 7 wraps to 0.
REQ-014 On a tick where dig wraps 7->0, Win, Lose, Roll, Dice1 and Dice2 SHALL be captured into snapshot registers; the glyphs SHALL use only the snapshot, never live inputs.
REQ-015 On the same 7->0 tick, the frame counter SHALL increment; at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink phase bp.
REQ-016 Anode and Cathode SHALL be registered: each edge, Anode <= 8'hFF if cnt < 2, else all ones with bit dig cleared. Cathode <= glyph(dig, snapshot, bp). Both use the pre-edge cnt and dig, giving 1-cycle latency.
REQ-017 Glyph codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F, dash=3F, r=2F, P=0C, L=47, E=06.
REQ-018 Digit 0 SHALL show snapshot Dice1, and digit 1 SHALL show snapshot Dice2. A value of 0 or 7 shows dash.
REQ-019 Sum = Dice1+Dice2 SHALL be computed 4 bits wide from the snapshot. Digit 3 shows the sum ones and digit 4 shows the sum tens.
REQ-020 Digit 4 SHALL be blank when the sum is < 10. Both digits 3 and 4 SHALL be blank if either die is invalid.
REQ-021 Digits 2, 5 and 6 SHALL always be blank.
REQ-022 Digit 7 status, in priority order:
  - Win&Lose -> E, steady.
  - Win -> P when bp=1, blank when bp=0.
  - Lose -> L when bp=1, blank when bp=0.
  - Roll -> r, steady.
  - Otherwise blank.
REQ-023 Input changes mid-frame SHALL NOT alter any displayed glyph until the next 7->0 tick.
REQ-024 Exactly zero or one Anode bit SHALL be low in every cycle.

Reset
REQ-025 While reset=1 at an edge, the following SHALL take these values:
  - cnt=0, dig=0, frame counter=0, bp=1.
  - All snapshot bits=0.
  - Anode=8'hFF, Cathode=7'h7F.
REQ-026 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately. Scanning restarts from digit 0 with cnt=0 on the first edge after reset deasserts.
REQ-027 Until the first post-reset frame capture, dice digits SHALL show dash (snapshot 0) and the status digit SHALL be blank.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset, then 40 cycles idle -> Anode sequence per slot is FF,FF,FE,FE then FF,FF,FD,FD, and so on. Digits 0/1 show Cathode 3F; after the first frame, digit 7 shows 7F.
REQ-029 Dice1=3, Dice2=4, Win=1 held -> after the first capture:
  - digit0=30, digit1=19, digit3=78, digit4=7F.
  - digit7 alternates 0C / 7F every 2 frames.
REQ-030 Dice1=6, Dice2=5, Lose=1 -> digit3=79, digit4=79, digit7 blinks 47. Win=Lose=1 -> digit7 steady 06.
REQ-031 Change Dice1 from 2 to 5 while digit 4 is active -> digit 0 keeps showing 24 until after the next 7->0 tick, then shows 12.
REQ-032 Dice1=7, Dice2=0, Roll=1 -> digits 0/1 show 3F, digits 3/4 show 7F, digit7 shows 2F.
REQ-033 Assert reset for 1 cycle while dig=5 and cnt=2 -> the next edge gives Anode=FF, Cathode=7F. Scanning resumes at digit 0, and the snapshot and bp are cleared and set per REQ-025.
